// File: rtl/space_invaders_pkg.sv
`default_nettype none
// ============================================================================
// Module      : space_invaders_pkg
// Description : Screen geometry, colour codes, coordinate widths and the
//               drawer state encoding shared by the sprite drawers.
// Revision    : 1.0 - initial release
// ============================================================================
package space_invaders_pkg;

  // Visible area of the 160x120 VGA adapter
  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;

  // Pixel coordinate widths on the adapter port
  localparam int X_W = 8;
  localparam int Y_W = 7;

  // 3-bit colour codes
  localparam logic [2:0] BLACK = 3'b000;
  localparam logic [2:0] GREEN = 3'b010;
  localparam logic [2:0] WHITE = 3'b111;
  localparam logic [2:0] RED   = 3'b100;

  // Drawer sequencing states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ERASE = 2'd1,
    DRAW  = 2'd2,
    DONE  = 2'd3
  } drawer_state_t;

endpackage
`default_nettype wire

// File: rtl/sprite_scanner.sv
`default_nettype none
// ============================================================================
// Module      : sprite_scanner
// Description : Row-major col/row counter for walking a sprite rectangle one
//               pixel per cycle. The col/row outputs are the counter values
//               that will hold after the coming edge, so a caller can register
//               pixel data in step with the counter.
// Revision    : 1.0 - initial release
// ============================================================================
module sprite_scanner #(
  parameter int SPRITE_W = 8,
  parameter int SPRITE_H = 6,
  parameter int CW       = (SPRITE_W > 1) ? $clog2(SPRITE_W) : 1,
  parameter int RW       = (SPRITE_H > 1) ? $clog2(SPRITE_H) : 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start,
  input  logic          advance,
  output logic [CW-1:0] col,
  output logic [RW-1:0] row,
  output logic          last_pixel
);

  localparam logic [CW-1:0] COL_LAST = CW'(SPRITE_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(SPRITE_H - 1);

  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;

  // Next counter value: restart on start, otherwise step col then row
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (start) begin
      col_d = '0;
      row_d = '0;
    end else if (advance) begin
      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  // Counter registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  assign col        = col_d;
  assign row        = row_d;
  assign last_pixel = (col_q == COL_LAST) && (row_q == ROW_LAST);

endmodule
`default_nettype wire

// File: rtl/alien_sprite_drawer.sv
`default_nettype none
// ============================================================================
// Module      : alien_sprite_drawer
// Description : Erases an alien's previous rectangle in background colour and
//               rasterises its bitmap at the new position, one pixel per cycle
//               to the 160x120 VGA adapter. Off-screen pixels are suppressed
//               without changing timing.
// Revision    : 1.0 - initial release
// ============================================================================
module alien_sprite_drawer #(
  parameter int                           SPRITE_W      = 8,
  parameter int                           SPRITE_H      = 6,
  parameter logic [SPRITE_W*SPRITE_H-1:0] SPRITE_BITMAP = 48'hC33CFFDB7E18,
  parameter logic [2:0]                   FG_COLOUR     = space_invaders_pkg::GREEN,
  parameter logic [2:0]                   BG_COLOUR     = space_invaders_pkg::BLACK,
  parameter int                           SCREEN_W      = space_invaders_pkg::SCREEN_W,
  parameter int                           SCREEN_H      = space_invaders_pkg::SCREEN_H
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic                               start,
  input  logic                               clear,
  input  logic [space_invaders_pkg::X_W-1:0] x_pos,
  input  logic [space_invaders_pkg::Y_W-1:0] y_pos,
  output logic [space_invaders_pkg::X_W-1:0] vga_x,
  output logic [space_invaders_pkg::Y_W-1:0] vga_y,
  output logic [2:0]                         vga_colour,
  output logic                               vga_plot,
  output logic                               busy,
  output logic                               done
);

  import space_invaders_pkg::*;

  localparam int N  = SPRITE_W * SPRITE_H;
  localparam int CW = (SPRITE_W > 1) ? $clog2(SPRITE_W) : 1;
  localparam int RW = (SPRITE_H > 1) ? $clog2(SPRITE_H) : 1;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  // Clip limits sized to the unwrapped address sums
  localparam logic [X_W:0] X_LIMIT = (X_W + 1)'(SCREEN_W);
  localparam logic [Y_W:0] Y_LIMIT = (Y_W + 1)'(SCREEN_H);

  drawer_state_t  state_q, state_d;
  logic [X_W-1:0] new_x_q, new_x_d, prev_x_q, prev_x_d;
  logic [Y_W-1:0] new_y_q, new_y_d, prev_y_q, prev_y_d;
  logic           has_prev_q, has_prev_d;
  logic           is_clear_q, is_clear_d;

  logic [X_W-1:0] vga_x_q, vga_x_d;
  logic [Y_W-1:0] vga_y_q, vga_y_d;
  logic [2:0]     vga_colour_q, vga_colour_d;
  logic           vga_plot_q, vga_plot_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;

  logic           scan_start, scan_adv, last_pixel;
  logic [CW-1:0]  col_nxt;
  logic [RW-1:0]  row_nxt;

  logic [X_W-1:0] base_x;
  logic [Y_W-1:0] base_y;
  logic [X_W:0]   px;
  logic [Y_W:0]   py;
  logic [IW-1:0]  bit_idx;
  logic           pix_on;

  sprite_scanner #(
    .SPRITE_W (SPRITE_W),
    .SPRITE_H (SPRITE_H),
    .CW       (CW),
    .RW       (RW)
  ) u_scanner (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (scan_start),
    .advance    (scan_adv),
    .col        (col_nxt),
    .row        (row_nxt),
    .last_pixel (last_pixel)
  );

  // Sequencing: accept requests in IDLE, step ERASE -> DRAW -> DONE
  always_comb begin
    state_d    = state_q;
    new_x_d    = new_x_q;
    new_y_d    = new_y_q;
    prev_x_d   = prev_x_q;
    prev_y_d   = prev_y_q;
    has_prev_d = has_prev_q;
    is_clear_d = is_clear_q;
    scan_start = 1'b0;
    scan_adv   = 1'b0;
    case (state_q)
      IDLE: begin
        if (clear) begin
          // clear takes priority over a simultaneous start
          is_clear_d = 1'b1;
          if (has_prev_q) begin
            state_d    = ERASE;
            scan_start = 1'b1;
          end else begin
            state_d = DONE;
          end
        end else if (start) begin
          is_clear_d = 1'b0;
          new_x_d    = x_pos;
          new_y_d    = y_pos;
          state_d    = has_prev_q ? ERASE : DRAW;
          scan_start = 1'b1;
        end
      end
      ERASE: begin
        if (last_pixel) begin
          if (is_clear_q) begin
            state_d    = DONE;
            has_prev_d = 1'b0;
          end else begin
            state_d    = DRAW;
            scan_start = 1'b1;
          end
        end else begin
          scan_adv = 1'b1;
        end
      end
      DRAW: begin
        if (last_pixel) begin
          state_d    = DONE;
          prev_x_d   = new_x_q;
          prev_y_d   = new_y_q;
          has_prev_d = 1'b1;
        end else begin
          scan_adv = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Pixel for the coming cycle, derived from next state and next counters
  always_comb begin
    base_x       = (state_d == ERASE) ? prev_x_q : new_x_d;
    base_y       = (state_d == ERASE) ? prev_y_q : new_y_d;
    px           = {1'b0, base_x} + (X_W + 1)'(col_nxt);
    py           = {1'b0, base_y} + (Y_W + 1)'(row_nxt);
    bit_idx      = IW'(int'(row_nxt) * SPRITE_W + int'(col_nxt));
    pix_on       = SPRITE_BITMAP[bit_idx];
    vga_x_d      = '0;
    vga_y_d      = '0;
    vga_colour_d = '0;
    vga_plot_d   = 1'b0;
    if ((state_d == ERASE) || (state_d == DRAW)) begin
      vga_x_d      = px[X_W-1:0];
      vga_y_d      = py[Y_W-1:0];
      vga_colour_d = ((state_d == DRAW) && pix_on) ? FG_COLOUR : BG_COLOUR;
      vga_plot_d   = (px < X_LIMIT) && (py < Y_LIMIT);
    end
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  // State, bookkeeping and registered outputs; reset aborts any operation
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      new_x_q      <= '0;
      new_y_q      <= '0;
      prev_x_q     <= '0;
      prev_y_q     <= '0;
      has_prev_q   <= 1'b0;
      is_clear_q   <= 1'b0;
      vga_x_q      <= '0;
      vga_y_q      <= '0;
      vga_colour_q <= '0;
      vga_plot_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      new_x_q      <= new_x_d;
      new_y_q      <= new_y_d;
      prev_x_q     <= prev_x_d;
      prev_y_q     <= prev_y_d;
      has_prev_q   <= has_prev_d;
      is_clear_q   <= is_clear_d;
      vga_x_q      <= vga_x_d;
      vga_y_q      <= vga_y_d;
      vga_colour_q <= vga_colour_d;
      vga_plot_q   <= vga_plot_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign vga_x      = vga_x_q;
  assign vga_y      = vga_y_q;
  assign vga_colour = vga_colour_q;
  assign vga_plot   = vga_plot_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule
`default_nettype wire

// File: tb/tb_alien_sprite_drawer.sv
`default_nettype none
// ============================================================================
// Module      : tb_alien_sprite_drawer
// Description : Self-checking bench for alien_sprite_drawer. A reference
//               model turns each request into the list of per-cycle outputs
//               it must produce; each scenario task compares the DUT
//               against that list.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alien_sprite_drawer;

  localparam int          W  = 8;
  localparam int          H  = 6;
  localparam int          N  = W * H;
  localparam logic [47:0] BM = 48'hC33CFFDB7E18;
  localparam logic [2:0]  FG = 3'b010;
  localparam logic [2:0]  BG = 3'b000;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic       clear = 1'b0;
  logic [7:0] x_pos = '0;
  logic [6:0] y_pos = '0;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       vga_plot;
  logic       busy;
  logic       done;

  int total = 0;
  int bad   = 0;

  // Per-cycle record: {plot, done, busy, x[7:0], y[6:0], colour[2:0]}
  logic [20:0] exp_q[$];
  logic [20:0] msk_q[$];
  logic [20:0] obs_q[$];

  // Reference model memory of what is on screen
  bit         m_has_prev = 1'b0;
  logic [7:0] m_prev_x   = '0;
  logic [6:0] m_prev_y   = '0;

  alien_sprite_drawer #(
    .SPRITE_W      (W),
    .SPRITE_H      (H),
    .SPRITE_BITMAP (BM),
    .FG_COLOUR     (FG),
    .BG_COLOUR     (BG),
    .SCREEN_W      (160),
    .SCREEN_H      (120)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .clear      (clear),
    .x_pos      (x_pos),
    .y_pos      (y_pos),
    .vga_x      (vga_x),
    .vga_y      (vga_y),
    .vga_colour (vga_colour),
    .vga_plot   (vga_plot),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  // Append one rectangle scan (row-major) to the expectation list
  task automatic push_scan(input logic [7:0] bx, input logic [6:0] by, input bit drw);
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        int         px;
        int         py;
        bit         on;
        logic [2:0] col;
        logic [8:0] pxv;
        logic [7:0] pyv;
        px  = int'(bx) + c;
        py  = int'(by) + r;
        on  = (px < 160) && (py < 120);
        col = (drw && BM[r * W + c]) ? FG : BG;
        pxv = 9'(px);
        pyv = 8'(py);
        exp_q.push_back({on, 1'b0, 1'b1, pxv[7:0], pyv[6:0], col});
        msk_q.push_back({3'b111, 8'hFF, 7'h7F, (on ? 3'b111 : 3'b000)});
      end
    end
  endtask

  // Expected cycles t+1.. for one request, then update the model's screen memory
  task automatic model_op(input bit s, input bit c, input logic [7:0] x, input logic [6:0] y);
    bit do_clear;
    do_clear = c;
    exp_q.delete();
    msk_q.delete();
    if (m_has_prev) push_scan(m_prev_x, m_prev_y, 1'b0);
    if (!do_clear && s) push_scan(x, y, 1'b1);
    exp_q.push_back({3'b011, 18'h0});
    msk_q.push_back({3'b111, 18'h0});
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back({3'b000, 18'h0});
      msk_q.push_back({3'b111, 18'h0});
    end
    if (do_clear) begin
      m_has_prev = 1'b0;
    end else begin
      m_has_prev = 1'b1;
      m_prev_x   = x;
      m_prev_y   = y;
    end
  endtask

  // Issue a request and record ncyc cycles of DUT outputs starting at t+1
  task automatic do_op(input bit s, input bit c, input logic [7:0] x, input logic [6:0] y,
                       input int ncyc, input int pulse_at, input int rst_at);
    obs_q.delete();
    @(negedge clk);
    start = s;
    clear = c;
    x_pos = x;
    y_pos = y;
    @(posedge clk);
    #1;
    start = 1'b0;
    clear = 1'b0;
    for (int k = 1; k <= ncyc; k++) begin
      @(negedge clk);
      obs_q.push_back({vga_plot, done, busy, vga_x, vga_y, vga_colour});
      x_pos = 8'($urandom);
      y_pos = 7'($urandom);
      start = (k == pulse_at);
      if (k == rst_at) reset_n = 1'b0;
    end
    start   = 1'b0;
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if ({vga_plot, done, busy, vga_x, vga_y, vga_colour} !== 21'h0) begin
      bad++;
      $display("FAIL reset outputs got=%h want=0", {vga_plot, done, busy, vga_x, vga_y, vga_colour});
    end
    reset_n = 1'b1;
    m_has_prev = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_first_draw();
    model_op(1'b1, 1'b0, 8'd10, 7'd20);
    do_op(1'b1, 1'b0, 8'd10, 7'd20, exp_q.size(), -1, -1);
    for (int k = 0; k < exp_q.size(); k++) begin
      total++;
      if ((obs_q[k] & msk_q[k]) !== (exp_q[k] & msk_q[k])) begin
        bad++;
        $display("FAIL first_draw cyc=t+%0d got=%h want=%h", k + 1, obs_q[k] & msk_q[k], exp_q[k] & msk_q[k]);
      end
    end
  endtask

  task automatic test_redraw();
    model_op(1'b1, 1'b0, 8'd12, 7'd20);
    do_op(1'b1, 1'b0, 8'd12, 7'd20, exp_q.size(), -1, -1);
    for (int k = 0; k < exp_q.size(); k++) begin
      total++;
      if ((obs_q[k] & msk_q[k]) !== (exp_q[k] & msk_q[k])) begin
        bad++;
        $display("FAIL redraw cyc=t+%0d got=%h want=%h", k + 1, obs_q[k] & msk_q[k], exp_q[k] & msk_q[k]);
      end
    end
  endtask

  task automatic test_clear();
    for (int pass = 0; pass < 2; pass++) begin
      model_op(1'b0, 1'b1, 8'd0, 7'd0);
      do_op(1'b0, 1'b1, 8'd0, 7'd0, exp_q.size(), -1, -1);
      for (int k = 0; k < exp_q.size(); k++) begin
        total++;
        if ((obs_q[k] & msk_q[k]) !== (exp_q[k] & msk_q[k])) begin
          bad++;
          $display("FAIL clear%0d cyc=t+%0d got=%h want=%h", pass, k + 1, obs_q[k] & msk_q[k], exp_q[k] & msk_q[k]);
        end
      end
    end
  endtask

  task automatic test_clip();
    model_op(1'b1, 1'b0, 8'd156, 7'd117);
    do_op(1'b1, 1'b0, 8'd156, 7'd117, exp_q.size(), -1, -1);
    for (int k = 0; k < exp_q.size(); k++) begin
      total++;
      if ((obs_q[k] & msk_q[k]) !== (exp_q[k] & msk_q[k])) begin
        bad++;
        $display("FAIL clip cyc=t+%0d got=%h want=%h", k + 1, obs_q[k] & msk_q[k], exp_q[k] & msk_q[k]);
      end
    end
  endtask

  task automatic test_start_and_clear();
    model_op(1'b1, 1'b1, 8'd70, 7'd30);
    do_op(1'b1, 1'b1, 8'd70, 7'd30, exp_q.size(), -1, -1);
    for (int k = 0; k < exp_q.size(); k++) begin
      total++;
      if ((obs_q[k] & msk_q[k]) !== (exp_q[k] & msk_q[k])) begin
        bad++;
        $display("FAIL start_and_clear cyc=t+%0d got=%h want=%h", k + 1, obs_q[k] & msk_q[k], exp_q[k] & msk_q[k]);
      end
    end
  endtask

  task automatic test_ignore_mid_start();
    model_op(1'b1, 1'b0, 8'd40, 7'd50);
    do_op(1'b1, 1'b0, 8'd40, 7'd50, exp_q.size(), 20, -1);
    for (int k = 0; k < exp_q.size(); k++) begin
      total++;
      if ((obs_q[k] & msk_q[k]) !== (exp_q[k] & msk_q[k])) begin
        bad++;
        $display("FAIL ignore_mid_start cyc=t+%0d got=%h want=%h", k + 1, obs_q[k] & msk_q[k], exp_q[k] & msk_q[k]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int rst_at;
    // clear first so the aborted request is a plain draw
    model_op(1'b0, 1'b1, 8'd0, 7'd0);
    do_op(1'b0, 1'b1, 8'd0, 7'd0, exp_q.size(), -1, -1);
    model_op(1'b1, 1'b0, 8'd50, 7'd60);
    rst_at = 10;
    do_op(1'b1, 1'b0, 8'd50, 7'd60, rst_at + 1, -1, rst_at);
    for (int k = 0; k < rst_at; k++) begin
      total++;
      if ((obs_q[k] & msk_q[k]) !== (exp_q[k] & msk_q[k])) begin
        bad++;
        $display("FAIL reset_mid_pre cyc=t+%0d got=%h want=%h", k + 1, obs_q[k] & msk_q[k], exp_q[k] & msk_q[k]);
      end
    end
    total++;
    if (obs_q[rst_at] !== 21'h0) begin
      bad++;
      $display("FAIL reset_mid_abort got=%h want=0", obs_q[rst_at]);
    end
    m_has_prev = 1'b0;
    @(negedge clk);
    model_op(1'b1, 1'b0, 8'd30, 7'd40);
    do_op(1'b1, 1'b0, 8'd30, 7'd40, exp_q.size(), -1, -1);
    for (int k = 0; k < exp_q.size(); k++) begin
      total++;
      if ((obs_q[k] & msk_q[k]) !== (exp_q[k] & msk_q[k])) begin
        bad++;
        $display("FAIL reset_mid_after cyc=t+%0d got=%h want=%h", k + 1, obs_q[k] & msk_q[k], exp_q[k] & msk_q[k]);
      end
    end
  endtask

  task automatic test_random_ops();
    for (int i = 0; i < 8; i++) begin
      int         op;
      bit         s;
      bit         c;
      logic [7:0] x;
      logic [6:0] y;
      op = $urandom_range(0, 2);
      s  = (op != 1);
      c  = (op != 0);
      x  = 8'($urandom);
      y  = 7'($urandom);
      model_op(s, c, x, y);
      do_op(s, c, x, y, exp_q.size(), -1, -1);
      for (int k = 0; k < exp_q.size(); k++) begin
        total++;
        if ((obs_q[k] & msk_q[k]) !== (exp_q[k] & msk_q[k])) begin
          bad++;
          $display("FAIL random%0d op=%0d cyc=t+%0d got=%h want=%h", i, op, k + 1, obs_q[k] & msk_q[k], exp_q[k] & msk_q[k]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_first_draw();
    test_redraw();
    test_clear();
    test_clip();
    test_start_and_clear();
    test_ignore_mid_start();
    test_reset_mid();
    test_random_ops();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
